lru_set_array: RTL and testbench

LRU_SET_ARRAY -- requirements
Module: lru_set_array

---
 rtl/lru_set_array.sv | 203 ++++++++++++++++++++
 tb/tb_lru_set_array.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lru_set_array.sv
// lru_set_array
//   Per-set true-LRU tracker built on age matrices. Each of SETS sets keeps a
//   WAYS x WAYS age matrix M (M[i][j]=1: way i is more recent than way j) and a
//   valid vector V. Ways are touched (made valid + MRU) or invalidated (made
//   invalid + LRU). A query returns a one-hot victim one cycle later: the
//   lowest unlocked invalid way if any, otherwise the unlocked LRU way.
//
// Ports
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   ready               : high once every set has been initialised
//   touch_valid/set/way : mark a way valid and most-recently-used (one-hot way)
//   inv_valid/set/way   : mark a way invalid and least-recently-used (one-hot way)
//   query_valid/set     : victim request; lock_mask excludes ways from the choice
//   victim_valid        : one-cycle pulse carrying the registered query result
//   victim_way          : one-hot victim, or zero when nothing is selectable
//   victim_invalid      : victim was chosen because it holds no valid data
//   victim_none         : every way was locked
module lru_set_array #(
  parameter int SETS = 16,
  parameter int WAYS = 4,
  parameter int SW   = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic            touch_valid,
  input  logic [SW-1:0]   touch_set,
  input  logic [WAYS-1:0] touch_way,
  input  logic            inv_valid,
  input  logic [SW-1:0]   inv_set,
  input  logic [WAYS-1:0] inv_way,
  input  logic            query_valid,
  input  logic [SW-1:0]   query_set,
  input  logic [WAYS-1:0] lock_mask,
  output logic            victim_valid,
  output logic [WAYS-1:0] victim_way,
  output logic            victim_invalid,
  output logic            victim_none
);

  localparam int WW = WAYS * WAYS;

  // Bit (i*WAYS + j) of a packed matrix holds M[i][j].
  function automatic logic [WW-1:0] init_matrix();
    logic [WW-1:0] m;
    m = '0;
    for (int i = 0; i < WAYS; i++)
      for (int j = 0; j < WAYS; j++)
        m[i*WAYS+j] = (i > j);
    return m;
  endfunction

  function automatic logic [WW-1:0] apply_touch(logic [WW-1:0] m, logic [WAYS-1:0] k);
    logic [WW-1:0] r;
    r = m;
    for (int i = 0; i < WAYS; i++)
      for (int j = 0; j < WAYS; j++) begin
        if (k[i] && (i != j)) r[i*WAYS+j] = 1'b1;
        if (k[j])             r[i*WAYS+j] = 1'b0;
      end
    return r;
  endfunction

  function automatic logic [WW-1:0] apply_inv(logic [WW-1:0] m, logic [WAYS-1:0] k);
    logic [WW-1:0] r;
    r = m;
    for (int i = 0; i < WAYS; i++)
      for (int j = 0; j < WAYS; j++) begin
        if (k[i])             r[i*WAYS+j] = 1'b0;
        if (k[j] && (i != j)) r[i*WAYS+j] = 1'b1;
      end
    return r;
  endfunction

  function automatic logic is_onehot(logic [WAYS-1:0] x);
    return (x != '0) && ((x & (x - {{(WAYS-1){1'b0}}, 1'b1})) == '0);
  endfunction

  function automatic logic [WAYS-1:0] lowest_bit(logic [WAYS-1:0] x);
    return x & (~x + {{(WAYS-1){1'b0}}, 1'b1});
  endfunction

  localparam logic [WW-1:0] INIT_M = init_matrix();

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] cnt_reg, cnt_next;
  logic          init_we;

  logic [WW-1:0]   m_mem  [SETS];
  logic [WAYS-1:0] v_mem  [SETS];
  logic [WW-1:0]   m_next [SETS];
  logic [WAYS-1:0] v_next [SETS];

  logic touch_en, inv_en;

  // ---------------- init / run sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_we    = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_we  = 1'b1;
        cnt_next = cnt_reg + SW'(1);
        if (cnt_reg == SW'(SETS - 1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state_reg == ST_RUN);

  // Malformed (non one-hot) requests are dropped rather than corrupting the order.
  assign touch_en = touch_valid && ready && !reset && is_onehot(touch_way);
  assign inv_en   = inv_valid   && ready && !reset && is_onehot(inv_way);

  // ---------------- set state update ----------------
  // Touch is applied before invalidate so a same-way collision ends invalid/LRU.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      m_next[s] = m_mem[s];
      v_next[s] = v_mem[s];
      if (init_we && (cnt_reg == SW'(s))) begin
        m_next[s] = INIT_M;
        v_next[s] = '0;
      end else begin
        if (touch_en && (touch_set == SW'(s))) begin
          m_next[s] = apply_touch(m_next[s], touch_way);
          v_next[s] = v_next[s] | touch_way;
        end
        if (inv_en && (inv_set == SW'(s))) begin
          m_next[s] = apply_inv(m_next[s], inv_way);
          v_next[s] = v_next[s] & ~inv_way;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SETS; s++) begin
      m_mem[s] <= m_next[s];
      v_mem[s] <= v_next[s];
    end
  end

  // ---------------- victim selection ----------------
  // Reads the stored (pre-update) state, so same-cycle touches are not seen.
  logic [WW-1:0]   q_m;
  logic [WAYS-1:0] q_v, unlocked, inv_cand, lru_cand;

  assign q_m      = m_mem[query_set];
  assign q_v      = v_mem[query_set];
  assign unlocked = ~lock_mask;
  assign inv_cand = unlocked & ~q_v;

  // A way is LRU within the unlocked subset when it is newer than none of them.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lru
    assign lru_cand[gi] = unlocked[gi] && ((q_m[gi*WAYS +: WAYS] & unlocked) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      victim_valid   <= 1'b0;
      victim_way     <= '0;
      victim_invalid <= 1'b0;
      victim_none    <= 1'b0;
    end else begin
      victim_valid <= 1'b0;
      if (query_valid && ready) begin
        victim_valid <= 1'b1;
        if (unlocked == '0) begin
          victim_way     <= '0;
          victim_invalid <= 1'b0;
          victim_none    <= 1'b1;
        end else if (inv_cand != '0) begin
          victim_way     <= lowest_bit(inv_cand);
          victim_invalid <= 1'b1;
          victim_none    <= 1'b0;
        end else begin
          victim_way     <= lowest_bit(lru_cand);
          victim_invalid <= 1'b0;
          victim_none    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lru_set_array.sv
// Directed testbench for lru_set_array (SETS=16, WAYS=4).
module tb_lru_set_array;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic       touch_valid;
  logic [3:0] touch_set;
  logic [3:0] touch_way;
  logic       inv_valid;
  logic [3:0] inv_set;
  logic [3:0] inv_way;
  logic       query_valid;
  logic [3:0] query_set;
  logic [3:0] lock_mask;
  logic       victim_valid;
  logic [3:0] victim_way;
  logic       victim_invalid;
  logic       victim_none;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lru_set_array #(.SETS(16), .WAYS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ready          (ready),
    .touch_valid    (touch_valid),
    .touch_set      (touch_set),
    .touch_way      (touch_way),
    .inv_valid      (inv_valid),
    .inv_set        (inv_set),
    .inv_way        (inv_way),
    .query_valid    (query_valid),
    .query_set      (query_set),
    .lock_mask      (lock_mask),
    .victim_valid   (victim_valid),
    .victim_way     (victim_way),
    .victim_invalid (victim_invalid),
    .victim_none    (victim_none)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic touch(input logic [3:0] s, input logic [3:0] w);
    touch_valid = 1'b1; touch_set = s; touch_way = w;
    step();
    touch_valid = 1'b0;
  endtask

  task automatic query(input logic [3:0] s, input logic [3:0] lock);
    query_valid = 1'b1; query_set = s; lock_mask = lock;
    step();
    query_valid = 1'b0; lock_mask = 4'b0000;
  endtask

  task automatic chk_victim(input string tag, input logic [3:0] way,
                            input logic inv, input logic none);
    chk({tag, ".valid"},   32'(victim_valid),   32'd1);
    chk({tag, ".way"},     32'(victim_way),     32'(way));
    chk({tag, ".invalid"}, 32'(victim_invalid), 32'(inv));
    chk({tag, ".none"},    32'(victim_none),    32'(none));
  endtask

  task automatic count_init(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, ".ready_low_cycles"}, 32'(n), 32'd16);
    chk({tag, ".ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    touch_valid = 1'b0; touch_set = '0; touch_way = '0;
    inv_valid = 1'b0;   inv_set = '0;   inv_way = '0;
    query_valid = 1'b0; query_set = '0; lock_mask = '0;

    // reset state
    step();
    step();
    chk("rst.ready",          32'(ready),          32'd0);
    chk("rst.victim_valid",   32'(victim_valid),   32'd0);
    chk("rst.victim_way",     32'(victim_way),     32'd0);
    chk("rst.victim_invalid", 32'(victim_invalid), 32'd0);
    chk("rst.victim_none",    32'(victim_none),    32'd0);
    reset = 1'b0;
    count_init("init1");

    // fresh set: lowest invalid way
    query(4'd3, 4'b0000);
    chk_victim("q_set3", 4'b0001, 1'b1, 1'b0);
    step();
    chk("pulse_one_cycle", 32'(victim_valid), 32'd0);

    // set 5: fill all ways, LRU is way 0, then way 1 after re-touching way 0
    touch(4'd5, 4'b0001);
    touch(4'd5, 4'b0010);
    touch(4'd5, 4'b0100);
    touch(4'd5, 4'b1000);
    query(4'd5, 4'b0000);
    chk_victim("s5_lru0", 4'b0001, 1'b0, 1'b0);
    touch(4'd5, 4'b0001);
    query(4'd5, 4'b0000);
    chk_victim("s5_lru1", 4'b0010, 1'b0, 1'b0);

    // lock masks: order is 1<2<3<0
    query(4'd5, 4'b0010);
    chk_victim("s5_lock1", 4'b0100, 1'b0, 1'b0);
    query(4'd5, 4'b1111);
    chk_victim("s5_lockall", 4'b0000, 1'b0, 1'b1);

    // set 2: same-cycle touch+inv of way 3 with a query reading pre-cycle state
    touch(4'd2, 4'b0001);
    touch(4'd2, 4'b0010);
    touch(4'd2, 4'b0100);
    touch(4'd2, 4'b1000);
    touch_valid = 1'b1; touch_set = 4'd2; touch_way = 4'b1000;
    inv_valid   = 1'b1; inv_set   = 4'd2; inv_way   = 4'b1000;
    query_valid = 1'b1; query_set = 4'd2; lock_mask = 4'b0000;
    step();
    touch_valid = 1'b0; inv_valid = 1'b0; query_valid = 1'b0;
    chk_victim("s2_same_cycle", 4'b0001, 1'b0, 1'b0);
    query(4'd2, 4'b0000);
    chk_victim("s2_after", 4'b1000, 1'b1, 1'b0);

    // different sets in one cycle: touch set 7 way 0, invalidate set 5 way 2
    touch_valid = 1'b1; touch_set = 4'd7; touch_way = 4'b0001;
    inv_valid   = 1'b1; inv_set   = 4'd5; inv_way   = 4'b0100;
    step();
    touch_valid = 1'b0; inv_valid = 1'b0;
    query(4'd5, 4'b0000);
    chk_victim("s5_inv2", 4'b0100, 1'b1, 1'b0);
    query(4'd7, 4'b0000);
    chk_victim("s7_touch0", 4'b0010, 1'b1, 1'b0);

    // set 1: non one-hot touch is ignored
    touch(4'd1, 4'b0001);
    query(4'd1, 4'b0000);
    chk_victim("s1_before", 4'b0010, 1'b1, 1'b0);
    touch(4'd1, 4'b0110);
    query(4'd1, 4'b0000);
    chk_victim("s1_after", 4'b0010, 1'b1, 1'b0);

    // reset mid-INIT restarts initialisation; queries during INIT are dropped
    reset = 1'b1;
    step();
    reset = 1'b0;
    query_valid = 1'b1; query_set = 4'd0;
    step();
    chk("init_query_dropped", 32'(victim_valid), 32'd0);
    query_valid = 1'b0;
    repeat (6) step();
    chk("init_mid.ready", 32'(ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_init("init2");
    for (int s = 0; s < 16; s++) begin
      query(4'(s), 4'b0000);
      chk_victim($sformatf("reinit_set%0d", s), 4'b0001, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
